line_fetch_scheduler: RTL
=========================

LINE_FETCH_SCHEDULER -- requirements
Module: line_fetch_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line (words fetched per line).
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter V_TOTAL, default 525, total lines per frame including blanking.
REQ-004 Parameter ADDR_W, default 19, fetch address width.
REQ-005 Parameter BASE_ADDR, default 0, frame buffer base word address.
REQ-006 clk  in  1  pixel clock; single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  scheduler enable.
REQ-009 clear_status  in  1  one-cycle pulse; clears underflow and overrun flags.
REQ-010 y  in  10  current line from video timing.
REQ-011 end_of_line  in  1  high on the last pixel clock of each line.
REQ-012 start_of_frame  in  1  high on pixel (0,0).
REQ-013 vde  in  1  active-video qualifier.
REQ-014 fetch_req  out  1  line fetch request to memory reader.
REQ-015 fetch_addr  out  ADDR_W  start word address of the requested line.
REQ-016 fetch_line  out  10  line number requested.
REQ-017 fetch_bank  out  1  line buffer bank to write.
REQ-018 fetch_ack  in  1  request accepted when high together with fetch_req.
REQ-019 fetch_done  in  1  one-cycle pulse; requested line fully written.
REQ-020 rd_bank  out  1  bank the display reads, equal to y[0].
REQ-021 line_valid  out  1  vde AND bank rd_bank holds a ready line.
REQ-022 underflow  out  1  sticky; a needed line was not ready.
REQ-023 overrun  out  1  sticky; trigger arrived while a fetch was in flight.
REQ-024 frame_count  out  16  frames started while enabled.
REQ-025 busy  out  1  high in any state other than IDLE.

Function
REQ-026 Trigger: end_of_line AND enable; target t = (y+2) mod V_TOTAL; fetch issued only if t < V_ACTIVE; bank = t[0].
REQ-027 States: IDLE, REQ, WAIT_DONE; IDLE->REQ on valid trigger; REQ->WAIT_DONE when fetch_ack; WAIT_DONE->IDLE on fetch_done.
REQ-028 fetch_req high exactly in REQ; fetch_addr, fetch_line, fetch_bank registered on trigger and held stable until acceptance.
REQ-029 fetch_addr = (BASE_ADDR + t*H_ACTIVE) mod 2^ADDR_W, computed at full width before truncation.
REQ-030 fetch_done outside WAIT_DONE is ignored; fetch_ack outside REQ is ignored.
REQ-031 Trigger in WAIT_DONE in the same cycle as fetch_done: fetch completes, new target is latched, state goes to REQ next cycle, no overrun.
REQ-032 Any other trigger outside IDLE: trigger dropped, overrun set, in-flight fetch continues.
REQ-033 ready[1:0]: ready[fetch_bank] set on accepted fetch_done; ready[y[0]] cleared on end_of_line while y < V_ACTIVE; set wins when both hit one bank in a cycle.
REQ-034 armed set on fetch_done for line 0; cleared when enable low and state IDLE.
REQ-035 Underflow: on end_of_line with armed and (y+1) < V_ACTIVE and ready[(y+1)[0]] low, set underflow.
REQ-036 clear_status clears both sticky flags; a set event in the same cycle wins.
REQ-037 frame_count increments on start_of_frame AND enable; wraps 0xFFFF->0.
REQ-038 enable deassertion blocks new triggers only; an in-flight fetch runs to completion.

Reset
REQ-039 reset overrides all inputs: state IDLE, fetch_req 0, fetch_addr 0, fetch_line 0, fetch_bank 0, ready 0, armed 0, underflow 0, overrun 0, frame_count 0, busy 0.
REQ-040 reset mid-fetch abandons the request; the first fetch after reset comes only from a new trigger.

Verification
REQ-041 enable=1, end_of_line at y=523 -> next cycle fetch_req=1, fetch_line=0, fetch_bank=0, fetch_addr=0; at y=524 -> line 1, addr 640, bank 1.
REQ-042 ack 3 cycles after request, done 700 cycles later -> busy high throughout, ready[bank] set, line_valid high on next vde in that bank.
REQ-043 fetch_done withheld past next end_of_line trigger -> overrun=1, no second request issued; clear_status -> overrun=0.
REQ-044 armed, line 5 fetch never completes, end_of_line at y=4 -> underflow=1; end_of_line at y=479 or y=480 -> no fetch issued.
REQ-045 fetch_done and trigger in the same cycle -> no overrun, fetch_req high next cycle for new target.
REQ-046 reset pulsed while in WAIT_DONE -> all outputs at reset values next cycle; 10 start_of_frame pulses with enable=1 -> frame_count=10.

Source files
------------

// File: rtl/line_fetch_scheduler_if.sv
// Line-fetch handshake between the scheduler and the memory reader.
interface line_fetch_scheduler_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [9:0]        fetch_line;
  logic              fetch_bank;
  logic              fetch_ack;
  logic              fetch_done;

  modport master (
    output fetch_req, fetch_addr, fetch_line, fetch_bank,
    input  fetch_ack, fetch_done
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_line, fetch_bank,
    output fetch_ack, fetch_done
  );
endinterface

// File: rtl/line_fetch_scheduler.sv
// Schedules one line-buffer fetch two lines ahead of the display and tracks
// which of the two line banks holds a ready line.
module line_fetch_scheduler #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear_status,
  input  logic [9:0]                    y,
  input  logic                          end_of_line,
  input  logic                          start_of_frame,
  input  logic                          vde,
  line_fetch_scheduler_if.master        fbus,
  output logic                          rd_bank,
  output logic                          line_valid,
  output logic                          underflow,
  output logic                          overrun,
  output logic [15:0]                   frame_count,
  output logic                          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              fetch_req_q, fetch_req_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [9:0]        fetch_line_q, fetch_line_d;
  logic              fetch_bank_q, fetch_bank_d;
  logic [1:0]        ready_q, ready_d;
  logic              armed_q, armed_d;
  logic              underflow_q, underflow_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              busy_q, busy_d;

  logic [10:0] y_p1, y_p2, target;
  logic        trig_valid, done_acc, latch, set_ov, set_uf;

  // Target line two ahead of the display, wrapped at the frame height.
  always_comb begin
    y_p1       = 11'(y) + 11'd1;
    y_p2       = 11'(y) + 11'd2;
    target     = (y_p2 >= 11'(V_TOTAL)) ? (y_p2 - 11'(V_TOTAL)) : y_p2;
    trig_valid = end_of_line && enable && (target < 11'(V_ACTIVE));
    done_acc   = (state_q == S_WAIT) && fbus.fetch_done;
  end

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    fetch_line_d  = fetch_line_q;
    fetch_bank_d  = fetch_bank_q;
    ready_d       = ready_q;
    armed_d       = armed_q;
    frame_count_d = frame_count_q;
    latch         = 1'b0;
    set_ov        = 1'b0;
    set_uf        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig_valid) begin
          latch   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (fbus.fetch_ack) state_d = S_WAIT;
        if (trig_valid) set_ov = 1'b1;
      end
      S_WAIT: begin
        // A trigger landing on the completion cycle chains straight into the next fetch.
        if (fbus.fetch_done) begin
          if (trig_valid) begin
            latch   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else if (trig_valid) begin
          set_ov = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (latch) begin
      fetch_line_d = 10'(target);
      fetch_bank_d = target[0];
      fetch_addr_d = ADDR_W'(64'(BASE_ADDR) + 64'(target) * 64'(H_ACTIVE));
    end

    // Display consumes a bank at end of line; a completing fetch refills it and wins.
    if (end_of_line && (11'(y) < 11'(V_ACTIVE))) ready_d[y[0]] = 1'b0;
    if (done_acc) ready_d[fetch_bank_q] = 1'b1;

    if (done_acc && (fetch_line_q == 10'd0)) armed_d = 1'b1;
    else if (!enable && (state_q == S_IDLE)) armed_d = 1'b0;

    set_uf = end_of_line && armed_q && (y_p1 < 11'(V_ACTIVE)) && !ready_q[y_p1[0]];

    underflow_d = set_uf || (underflow_q && !clear_status);
    overrun_d   = set_ov || (overrun_q && !clear_status);

    if (start_of_frame && enable) frame_count_d = frame_count_q + 16'd1;

    fetch_req_d = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fetch_req_q   <= 1'b0;
      fetch_addr_q  <= '0;
      fetch_line_q  <= '0;
      fetch_bank_q  <= 1'b0;
      ready_q       <= '0;
      armed_q       <= 1'b0;
      underflow_q   <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_req_q   <= fetch_req_d;
      fetch_addr_q  <= fetch_addr_d;
      fetch_line_q  <= fetch_line_d;
      fetch_bank_q  <= fetch_bank_d;
      ready_q       <= ready_d;
      armed_q       <= armed_d;
      underflow_q   <= underflow_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
    end
  end

  assign fbus.fetch_req  = fetch_req_q;
  assign fbus.fetch_addr = fetch_addr_q;
  assign fbus.fetch_line = fetch_line_q;
  assign fbus.fetch_bank = fetch_bank_q;
  assign rd_bank         = y[0];
  assign line_valid      = vde && ready_q[y[0]];
  assign underflow       = underflow_q;
  assign overrun         = overrun_q;
  assign frame_count     = frame_count_q;
  assign busy            = busy_q;

endmodule
